// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the vector memory sequencer.
// Element extraction is width-generic up to VEC_MAX/ELEM_MAX bits.
package vec_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned VLEN_DEF = 16;
    localparam int unsigned IDX_W    = $clog2(VLEN_DEF);
    localparam int unsigned ELEM_MAX = 64;
    localparam int unsigned VEC_MAX  = 4096;

    function automatic logic [ELEM_MAX-1:0] get_elem(
        input logic [VEC_MAX-1:0] vec,
        input int unsigned        k,
        input int unsigned        dw
    );
        logic [VEC_MAX-1:0] s;
        s = vec >> (k * dw);
        return s[ELEM_MAX-1:0];
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Address accumulator and element index for the vector sequencer.
// Addresses advance by repeated addition of the latched stride.
module vec_addr_gen
    import vec_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int VLEN       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [ADDR_WIDTH-1:0]   base,
    input  logic [ADDR_WIDTH-1:0]   stride,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [$clog2(VLEN)-1:0] idx,
    output logic                    last
);

    localparam int IW = $clog2(VLEN);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [IW-1:0]         r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
        end else if (load) begin
            r_addr   <= base;
            r_stride <= stride;
            r_idx    <= '0;
        end else if (step) begin
            r_addr   <= r_addr + r_stride;
            r_idx    <= r_idx + 1'b1;
        end
    end

    assign addr = r_addr;
    assign idx  = r_idx;
    assign last = (r_idx == IW'(VLEN - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Vector load/store engine: one element per clock to single-port memory.
// Load data arrives one cycle after its address and is captured a cycle later.
module vector_mem_sequencer
    import vec_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 19,
    parameter int VLEN       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_store,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH-1:0]      stride,
    input  logic [VLEN*DATA_WIDTH-1:0] store_vec,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_we,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [VLEN*DATA_WIDTH-1:0] load_vec,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(VLEN);
    localparam int VW = VLEN * DATA_WIDTH;

    state_t          r_state;
    logic            r_is_store;
    logic [VW-1:0]   r_store_vec;
    logic            r_cap_vld;
    logic [IW-1:0]   r_cap_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [VW-1:0]   r_load_vec;

    logic            w_accept;
    logic            w_step;
    logic            w_last;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_idx_nxt;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_step    = (r_state == ISSUE) && !w_last;
    assign w_idx_nxt = w_idx + 1'b1;

    vec_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .VLEN       (VLEN)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .step   (w_step),
        .base   (base_addr),
        .stride (stride),
        .addr   (mem_addr),
        .idx    (w_idx),
        .last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_store  <= 1'b0;
            r_store_vec <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_load_vec  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cap_vld <= 1'b0;
            // rdata now belongs to the element issued last cycle
            if (r_cap_vld) begin
                r_load_vec[32'(r_cap_idx)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= ISSUE;
                        r_is_store  <= is_store;
                        r_store_vec <= store_vec;
                        r_busy      <= 1'b1;
                        r_we        <= is_store;
                        if (is_store) begin
                            r_wdata <= store_vec[DATA_WIDTH-1:0];
                        end
                    end
                end
                ISSUE: begin
                    r_cap_vld <= !r_is_store;
                    r_cap_idx <= w_idx;
                    if (w_last) begin
                        r_we    <= 1'b0;
                        r_state <= r_is_store ? DONE : DRAIN;
                        r_done  <= r_is_store;
                    end else begin
                        r_we <= r_is_store;
                        if (r_is_store) begin
                            r_wdata <= DATA_WIDTH'(get_elem(
                                VEC_MAX'(r_store_vec),
                                32'(w_idx_nxt),
                                unsigned'(DATA_WIDTH)));
                        end
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;
    assign load_vec  = r_load_vec;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer.
// Reference: per-op address list, shadow memory and expected load vector.
module tb_vector_mem_sequencer;

    localparam int DW = 16;
    localparam int AW = 19;
    localparam int VL = 16;
    localparam int VW = DW * VL;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          is_store = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [VW-1:0] store_vec = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [VW-1:0] load_vec;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [MSZ];
    logic [DW-1:0] ref_mem [MSZ];
    logic [VW-1:0] lv_exp = '0;

    vector_mem_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .VLEN       (VL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .stride    (stride),
        .store_vec (store_vec),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .load_vec  (load_vec),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // single-port memory, one-cycle read latency
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] b,
                                                 input logic [AW-1:0] s,
                                                 input int k);
        longint t;
        t = longint'(b) + longint'(k) * longint'(s);
        return AW'(t);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < VW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic scramble_inputs();
        is_store  = 1'($urandom);
        base_addr = AW'($urandom);
        stride    = AW'($urandom);
        store_vec = rand_vec();
    endtask

    task automatic run_op(input logic st, input logic [AW-1:0] b,
                          input logic [AW-1:0] s, input logic [VW-1:0] v,
                          input bit glitch);
        int            done_i;
        logic [AW-1:0] a;
        logic [VW-1:0] lv_new;
        done_i = st ? VL + 1 : VL + 2;
        lv_new = lv_exp;
        for (int k = 0; k < VL; k++) begin
            a = elem_addr(b, s, k);
            if (st) ref_mem[a] = v[k*DW +: DW];
            else lv_new[k*DW +: DW] = ref_mem[a];
        end
        is_store  = st;
        base_addr = b;
        stride    = s;
        store_vec = v;
        start     = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= done_i + 1; i++) begin
            @(negedge clk);
            start = glitch && (i == 3 || i == done_i);
            if (i == 1 || start) scramble_inputs();
            chk("busy", busy, (i <= done_i));
            chk("done", done, (i == done_i));
            chk("we", mem_we, (st && i <= VL));
            if (i <= VL) begin
                chk("addr", mem_addr, elem_addr(b, s, i - 1));
                if (st) chk("wdata", mem_wdata, v[(i-1)*DW +: DW]);
            end
            if (i >= done_i) chk("lvec", load_vec, lv_new);
        end
        start = 1'b0;
        lv_exp = lv_new;
        if (st) begin
            for (int k = 0; k < VL; k++) begin
                a = elem_addr(b, s, k);
                chk("mem", mem[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [AW-1:0] a;
        for (int i = 0; i < MSZ; i++) begin
            a = AW'(i);
            mem[i]     = a[15:0] ^ 16'hA5A5;
            ref_mem[i] = a[15:0] ^ 16'hA5A5;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_lvec", load_vec, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, AW'('h00100), AW'(1), '0, 1'b0);

        for (int k = 0; k < VL; k++) v[k*DW +: DW] = DW'(16'h1000 + k);
        run_op(1'b1, AW'('h7FFFE), AW'(1), v, 1'b0);

        run_op(1'b0, AW'('h00040), AW'(4), '0, 1'b1);
        run_op(1'b0, AW'('h7FFFC), AW'(1), '0, 1'b0);

        // abort a store while element 5 is on the bus
        for (int k = 0; k < VL; k++) v[k*DW +: DW] = DW'(16'hBEE0 + k);
        is_store  = 1'b1;
        base_addr = AW'('h00300);
        stride    = AW'(1);
        store_vec = v;
        start     = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("ab_addr", mem_addr, elem_addr(AW'('h300), AW'(1), i - 1));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_we", mem_we, 1'b0);
        chk("ab_lvec", load_vec, '0);
        chk("ab_addr0", mem_addr, '0);
        for (int k = 0; k < 6; k++) ref_mem['h300 + k] = v[k*DW +: DW];
        lv_exp = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("ab_done", done, 1'b0);
            chk("ab_we_idle", mem_we, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            a = AW'('h300 + k);
            chk("ab_mem", mem[a], ref_mem[a]);
        end

        for (int k = 0; k < VL; k++) v[k*DW +: DW] = DW'(k);
        run_op(1'b1, AW'('h00200), AW'(0), v, 1'b0);
        chk("s0_final", mem['h200], DW'(15));

        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] s;
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = AW'($urandom_range(1, 8));
                default: s = AW'($urandom);
            endcase
            run_op(1'($urandom), AW'($urandom), s, rand_vec(),
                   bit'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
Parametrised vector load/store engine between the vector execute stage and single-port data memory.
- Streams VLEN elements of DATA_WIDTH bits to or from memory, one element per clock.
- Element k is at address base + k*stride.
- Holds the pipeline stalled while active and pulses done on completion.
- Adds store mode, programmable stride, a start/done handshake, reset and correct read-latency alignment.

Parameters:
DATA_WIDTH, 16, element width in bits
ADDR_WIDTH, 19, memory word-address width
VLEN, 16, elements per vector (power of two, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
is_store  in  1  1=store vector to memory, 0=load vector from memory; latched at start
base_addr  in  ADDR_WIDTH  address of element 0; latched at start
stride  in  ADDR_WIDTH  unsigned address increment per element; latched at start
store_vec  in  VLEN*DATA_WIDTH  store data, element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; latched at start
mem_rdata  in  DATA_WIDTH  memory read data, valid exactly one cycle after mem_addr is presented
mem_addr  out  ADDR_WIDTH  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_WIDTH  memory write data
load_vec  out  VLEN*DATA_WIDTH  loaded vector, same packing as store_vec
busy  out  1  pipeline stall request; equals (state != IDLE)
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: on any cycle rst=1, the next state is IDLE. Reset values: mem_addr=0, mem_we=0, mem_wdata=0, load_vec=0, busy=0, done=0, element index=0. Reset overrides start and aborts any operation in flight; no further memory writes after the reset edge.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: when start=1, latch is_store, base_addr, stride and store_vec; idx=0; go to ISSUE.
  - ISSUE, one cycle per element k=0..VLEN-1: mem_addr = base + k*stride, truncated mod 2^ADDR_WIDTH (wraps, no error).
    - Store: mem_we=1, mem_wdata = element k.
    - Load: mem_we=0.
    - After k=VLEN-1: store goes to DONE; load goes to DRAIN.
  - DRAIN (load only): captures the final element; mem_we=0; go to DONE.
  - DONE: done=1 for exactly one cycle, busy still 1; go to IDLE.
- Load capture: in the cycle after issuing element k, mem_rdata is written into load_vec element k.
  - Elements update one at a time.
  - load_vec is fully valid from the DONE cycle and holds until the next load overwrites it.
  - Stores never modify load_vec.
- Timing, with start sampled at edge T:
  - ISSUE occupies cycles T+1..T+VLEN.
  - Store: done in T+VLEN+1. Load: DRAIN at T+VLEN+1, done in T+VLEN+2.
  - busy is high from T+1 through the done cycle inclusive.
- Addresses are generated by accumulation (previous address + stride), not by multiplication.
- start while busy=1 is ignored, not queued.
- start in the same cycle as done (state DONE) is ignored. A new start is accepted in the first IDLE cycle.
- Outside ISSUE: mem_we=0; mem_addr and mem_wdata hold their last values.
- stride=0 is legal: every access targets base. For a store, the last element wins.

Decomposition:
- Package vec_mem_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), the element-index width constant $clog2(VLEN), and a function that extracts element k from a packed vector.
- Sub-module vec_addr_gen: holds the address accumulator and element index. Inputs: load (base), step (add stride), rst. Outputs: addr, idx, last (idx==VLEN-1).
- The FSM and load capture stay in the top module.

Test Plan:
1. Load, default parameters: memory model returns mem[a] = a[15:0] ^ 16'hA5A5; base=19'h00100, stride=1 -> addresses 0x100..0x10F on consecutive cycles; load_vec[k] = (0x100+k) ^ 0xA5A5; done exactly VLEN+2 cycles after start; busy high for 18 cycles.
2. Store with wrap: base=19'h7FFFE, stride=1, store_vec[k]=16'h1000+k -> writes 0x1000 to 0x7FFFE, 0x1001 to 0x7FFFF, 0x1002 to 0x00000, ..., 0x100F to 0x0000D; mem_we high 16 cycles; done 17 cycles after start; load_vec unchanged.
3. Strided load: base=0x40, stride=4 -> mem_addr sequence 0x40, 0x44, ..., 0x7C; load_vec[15] = mem[0x7C].
4. start pulses at cycles T+3 and T+VLEN+2 (the DONE cycle) during a load -> both ignored, exactly one done pulse; a start at T+VLEN+3 is accepted.
5. rst asserted while issuing store element k=5 -> next cycle busy=0, mem_we=0, load_vec=0; memory holds only elements 0..5; no done pulse.
6. Store with stride=0, base=0x200, store_vec[k]=k -> 16 writes to 0x200; final mem[0x200]=15.
